tag_array_nway: RTL and testbench

Parametrised, set-associative tag store for the instruction cache. It holds NUM_ROWS x NUM_WAYS tag/valid entries in flops, performs a registered lookup with per-way hit detection, and suggests a replacement victim on every lookup. It accepts fills through a masked write port and supports a multi-cycle flush that invalidates the whole array. It sits between the fetch front end and the data array, and replaces the single-way SRAM-backed tag array.

---
 rtl/tag_array_nway_pkg.sv | 14 +
 rtl/tag_array_nway_victim_select.sv | 35 +++
 rtl/tag_array_nway.sv | 145 ++++++++++++++
 tb/tb_tag_array_nway.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_array_nway_pkg.sv
// Shared instruction-cache tag-store definitions: default geometry and the
// flush FSM state encoding.
package tag_array_nway_pkg;

  localparam int TAG_WIDTH_DEF = 8;
  localparam int NUM_ROWS_DEF  = 16;
  localparam int NUM_WAYS_DEF  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/tag_array_nway_victim_select.sv
// Replacement suggestion for one row: the first invalid way wins, otherwise
// the row's round-robin pointer picks the victim.
module tag_array_nway_victim_select
  import tag_array_nway_pkg::*;
#(
  parameter int NUM_WAYS = NUM_WAYS_DEF,
  parameter int RR_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [RR_WIDTH-1:0] rr,
  output logic [NUM_WAYS-1:0] victim
);

  logic found_s;

  // Priority scan for the lowest invalid way, falling back to the pointer.
  always_comb begin
    victim  = {NUM_WAYS{1'b0}};
    found_s = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_s && !valid[w]) begin
        victim[w] = 1'b1;
        found_s   = 1'b1;
      end else begin
        victim[w] = victim[w];
      end
    end
    if (!found_s) begin
      victim = NUM_WAYS'(1) << rr;
    end else begin
      victim = victim;
    end
  end

endmodule

// File: rtl/tag_array_nway.sv
// Flop-based set-associative tag store with registered lookup, per-way hit,
// victim suggestion, masked fills and a row-by-row flush sequencer.
module tag_array_nway
  import tag_array_nway_pkg::*;
#(
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int NUM_WAYS   = NUM_WAYS_DEF,
  parameter int ADDR_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_r_valid,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic                  i_w_valid,
  input  logic [ADDR_WIDTH-1:0] i_w_addr,
  input  logic [NUM_WAYS-1:0]   i_w_way,
  input  logic [TAG_WIDTH-1:0]  i_w_tag,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_hit,
  output logic [NUM_WAYS-1:0]   o_hit_way,
  output logic [NUM_WAYS-1:0]   o_victim_way,
  output logic                  o_ready
);

  localparam int RR_WIDTH = $clog2(NUM_WAYS);

  logic [TAG_WIDTH-1:0]  tag_r   [NUM_ROWS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_r [NUM_ROWS];
  logic [RR_WIDTH-1:0]   rr_r    [NUM_ROWS];
  state_e                state_r;
  logic [ADDR_WIDTH-1:0] flush_cnt_r;

  logic                  idle_s;
  logic                  take_s;
  logic                  rd_s;
  logic                  wr_s;
  logic [NUM_WAYS-1:0]   hit_way_s;
  logic [NUM_WAYS-1:0]   victim_s;

  // A flush request in IDLE swallows any lookup or fill issued alongside it.
  assign idle_s  = (state_r == ST_IDLE);
  assign o_ready = ~i_halt & idle_s;
  assign take_s  = o_ready & ~i_flush;
  assign rd_s    = take_s & i_r_valid;
  assign wr_s    = take_s & i_w_valid & (|i_w_way);

  // Per-way tag compare against the pre-write contents of the lookup row.
  always_comb begin
    hit_way_s = {NUM_WAYS{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_way_s[w] = valid_r[i_r_addr][w] & (tag_r[i_r_addr][w] == i_tag);
    end
  end

  tag_array_nway_victim_select #(
    .NUM_WAYS (NUM_WAYS),
    .RR_WIDTH (RR_WIDTH)
  ) u_victim_select (
    .valid  (valid_r[i_r_addr]),
    .rr     (rr_r[i_r_addr]),
    .victim (victim_s)
  );

  // Tag storage is never reset; validity lives in valid_r.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (i_w_way[w]) begin
          tag_r[i_w_addr][w] <= i_w_tag;
        end
      end
    end
  end

  // Flush FSM together with valid bits and round-robin pointers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= {ADDR_WIDTH{1'b0}};
      for (int r = 0; r < NUM_ROWS; r++) begin
        valid_r[r] <= {NUM_WAYS{1'b0}};
        rr_r[r]    <= {RR_WIDTH{1'b0}};
      end
    end else if (!i_halt) begin
      case (state_r)
        ST_IDLE: begin
          if (i_flush) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {ADDR_WIDTH{1'b0}};
          end else if (wr_s) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
              if (i_w_way[w]) begin
                valid_r[i_w_addr][w] <= 1'b1;
              end
            end
            rr_r[i_w_addr] <= rr_r[i_w_addr] + RR_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          valid_r[flush_cnt_r] <= {NUM_WAYS{1'b0}};
          rr_r[flush_cnt_r]    <= {RR_WIDTH{1'b0}};
          flush_cnt_r          <= flush_cnt_r + ADDR_WIDTH'(1);
          if (flush_cnt_r == ADDR_WIDTH'(NUM_ROWS - 1)) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          flush_cnt_r <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Lookup result registers; zeroed when no lookup was taken, held under halt.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_valid      <= 1'b0;
      o_tag        <= {TAG_WIDTH{1'b0}};
      o_hit        <= 1'b0;
      o_hit_way    <= {NUM_WAYS{1'b0}};
      o_victim_way <= {NUM_WAYS{1'b0}};
    end else if (!i_halt) begin
      if (rd_s) begin
        o_valid      <= 1'b1;
        o_tag        <= i_tag;
        o_hit        <= |hit_way_s;
        o_hit_way    <= hit_way_s;
        o_victim_way <= victim_s;
      end else begin
        o_valid      <= 1'b0;
        o_tag        <= {TAG_WIDTH{1'b0}};
        o_hit        <= 1'b0;
        o_hit_way    <= {NUM_WAYS{1'b0}};
        o_victim_way <= {NUM_WAYS{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_tag_array_nway.sv
// Self-checking bench for tag_array_nway: directed scenarios plus a random
// run compared against a behavioural model of the tag store.
module tb_tag_array_nway;

  localparam int TW = 8;
  localparam int NR = 16;
  localparam int NW = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_halt = 1'b0;
  logic          i_r_valid = 1'b0;
  logic [AW-1:0] i_r_addr = '0;
  logic [TW-1:0] i_tag = '0;
  logic          i_w_valid = 1'b0;
  logic [AW-1:0] i_w_addr = '0;
  logic [NW-1:0] i_w_way = '0;
  logic [TW-1:0] i_w_tag = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic [TW-1:0] o_tag;
  logic          o_hit;
  logic [NW-1:0] o_hit_way;
  logic [NW-1:0] o_victim_way;
  logic          o_ready;

  int n_checks = 0;
  int n_pass = 0;

  // behavioural model state
  bit [TW-1:0] m_tag [NR][NW];
  bit          m_valid [NR][NW];
  int          m_rr [NR];
  int          m_flush_left = 0;
  int          m_flush_row = 0;
  logic          e_valid = 1'b0;
  logic [TW-1:0] e_tag = '0;
  logic [NW-1:0] e_hit_way = '0;
  logic [NW-1:0] e_victim = '0;

  tag_array_nway dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_halt       (i_halt),
    .i_r_valid    (i_r_valid),
    .i_r_addr     (i_r_addr),
    .i_tag        (i_tag),
    .i_w_valid    (i_w_valid),
    .i_w_addr     (i_w_addr),
    .i_w_way      (i_w_way),
    .i_w_tag      (i_w_tag),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .o_tag        (o_tag),
    .o_hit        (o_hit),
    .o_hit_way    (o_hit_way),
    .o_victim_way (o_victim_way),
    .o_ready      (o_ready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_rr[r] = 0;
      for (int w = 0; w < NW; w++) m_valid[r][w] = 0;
    end
    m_flush_left = 0;
    m_flush_row = 0;
    e_valid = 1'b0; e_tag = '0; e_hit_way = '0; e_victim = '0;
  endtask

  task automatic clear_outputs_model();
    e_valid = 1'b0; e_tag = '0; e_hit_way = '0; e_victim = '0;
  endtask

  // Apply one clock of the architectural rules to the model, using current inputs.
  task automatic model_cycle();
    int v;
    if (i_halt) return;
    if (m_flush_left > 0) begin
      for (int w = 0; w < NW; w++) m_valid[m_flush_row][w] = 0;
      m_rr[m_flush_row] = 0;
      m_flush_row++;
      m_flush_left--;
      clear_outputs_model();
    end else if (i_flush) begin
      m_flush_left = NR;
      m_flush_row = 0;
      clear_outputs_model();
    end else begin
      if (i_r_valid) begin
        e_valid = 1'b1;
        e_tag = i_tag;
        e_hit_way = '0;
        v = -1;
        for (int w = 0; w < NW; w++) begin
          if (m_valid[i_r_addr][w] && m_tag[i_r_addr][w] == i_tag) e_hit_way[w] = 1'b1;
          if (v < 0 && !m_valid[i_r_addr][w]) v = w;
        end
        if (v < 0) v = m_rr[i_r_addr];
        e_victim = NW'(1 << v);
      end else begin
        clear_outputs_model();
      end
      if (i_w_valid && i_w_way != '0) begin
        for (int w = 0; w < NW; w++) begin
          if (i_w_way[w]) begin
            m_valid[i_w_addr][w] = 1;
            m_tag[i_w_addr][w] = i_w_tag;
          end
        end
        m_rr[i_w_addr] = (m_rr[i_w_addr] + 1) % NW;
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_halt = 1'b0; i_r_valid = 1'b0; i_w_valid = 1'b0; i_flush = 1'b0;
    i_w_way = '0;
  endtask

  task automatic do_lookup(input logic [AW-1:0] a, input logic [TW-1:0] t);
    idle_inputs();
    i_r_valid = 1'b1; i_r_addr = a; i_tag = t;
    step();
    i_r_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [NW-1:0] way, input logic [TW-1:0] t);
    idle_inputs();
    i_w_valid = 1'b1; i_w_addr = a; i_w_way = way; i_w_tag = t;
    step();
    i_w_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 arst_n = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_valid); else n_pass++;
    n_checks++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", o_ready); else n_pass++;
    @(posedge clk); #1;
    do_lookup(4'd3, 8'h00);
    n_checks++;
    if ({o_valid, o_hit, o_victim_way} !== {1'b1, 1'b0, 2'b01})
      $display("FAIL reset_lookup: got v=%0b hit=%0b victim=%b want v=1 hit=0 victim=01", o_valid, o_hit, o_victim_way);
    else n_pass++;
  endtask

  task automatic test_fill_lookup();
    do_fill(4'd5, 2'b10, 8'hA5);
    do_lookup(4'd5, 8'hA5);
    n_checks++;
    if ({o_valid, o_tag, o_hit, o_hit_way} !== {1'b1, 8'hA5, 1'b1, 2'b10})
      $display("FAIL fill_hit: got v=%0b tag=%h hit=%0b way=%b want 1/a5/1/10", o_valid, o_tag, o_hit, o_hit_way);
    else n_pass++;
    do_lookup(4'd5, 8'hA4);
    n_checks++;
    if ({o_hit, o_hit_way, o_victim_way} !== {1'b0, 2'b00, 2'b01})
      $display("FAIL fill_miss: got hit=%0b way=%b victim=%b want 0/00/01", o_hit, o_hit_way, o_victim_way);
    else n_pass++;
  endtask

  task automatic test_victim();
    do_fill(4'd2, 2'b01, 8'h10);
    do_fill(4'd2, 2'b10, 8'h20);
    do_lookup(4'd2, 8'h30);
    n_checks++;
    if (o_victim_way !== 2'b01) $display("FAIL victim_rr0: got %b want 01", o_victim_way); else n_pass++;
    do_fill(4'd2, 2'b01, 8'h11);
    do_lookup(4'd2, 8'h30);
    n_checks++;
    if (o_victim_way !== 2'b10) $display("FAIL victim_rr1: got %b want 10", o_victim_way); else n_pass++;
    do_fill(4'd2, 2'b00, 8'h55);
    do_lookup(4'd2, 8'h55);
    n_checks++;
    if ({o_hit, o_victim_way} !== {1'b0, 2'b10})
      $display("FAIL zero_mask_noop: got hit=%0b victim=%b want 0/10", o_hit, o_victim_way);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    i_r_valid = 1'b1; i_r_addr = 4'd7; i_tag = 8'h3C;
    i_w_valid = 1'b1; i_w_addr = 4'd7; i_w_way = 2'b01; i_w_tag = 8'h3C;
    step();
    idle_inputs();
    n_checks++;
    if ({o_valid, o_hit} !== 2'b10) $display("FAIL rbw_first: got v=%0b hit=%0b want 1/0", o_valid, o_hit); else n_pass++;
    do_lookup(4'd7, 8'h3C);
    n_checks++;
    if ({o_hit, o_hit_way} !== {1'b1, 2'b01}) $display("FAIL rbw_second: got hit=%0b way=%b want 1/01", o_hit, o_hit_way); else n_pass++;
  endtask

  task automatic test_flush();
    int cnt = 0;
    bit done = 0;
    do_fill(4'd0, 2'b01, 8'h77);
    do_fill(4'd15, 2'b11, 8'h88);
    idle_inputs();
    i_flush = 1'b1; i_r_valid = 1'b1; i_r_addr = 4'd0; i_tag = 8'h77;
    step();
    idle_inputs();
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL flush_drop_lookup: got v=%0b want 0", o_valid); else n_pass++;
    for (int i = 0; i < 40 && !done; i++) begin
      i_halt = (i == 5);
      i_r_valid = 1'b1; i_r_addr = 4'd15; i_tag = 8'h88;
      #1;
      if (o_ready) done = 1;
      else begin
        cnt++;
        step();
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0 at cycle %0d", o_valid, i); else n_pass++;
      end
    end
    idle_inputs();
    n_checks++;
    if (cnt !== 17) $display("FAIL flush_busy_cycles: got %0d want 17", cnt); else n_pass++;
    do_lookup(4'd0, 8'h77);
    n_checks++;
    if ({o_valid, o_hit} !== 2'b10) $display("FAIL flush_row0: got v=%0b hit=%0b want 1/0", o_valid, o_hit); else n_pass++;
    do_lookup(4'd15, 8'h88);
    n_checks++;
    if ({o_valid, o_hit, o_victim_way} !== {1'b1, 1'b0, 2'b01})
      $display("FAIL flush_row15: got v=%0b hit=%0b victim=%b want 1/0/01", o_valid, o_hit, o_victim_way);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    do_fill(4'd12, 2'b01, 8'hC1);
    do_fill(4'd13, 2'b10, 8'hD2);
    do_fill(4'd3, 2'b11, 8'h33);
    idle_inputs();
    i_flush = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) step();
    arst_n = 1'b0;
    model_reset();
    #2 arst_n = 1'b1;
    #1;
    n_checks++;
    if ({o_ready, o_valid} !== 2'b10) $display("FAIL midflush_ready: got rdy=%0b v=%0b want 1/0", o_ready, o_valid); else n_pass++;
    do_lookup(4'd12, 8'hC1);
    n_checks++;
    if ({o_valid, o_hit} !== 2'b10) $display("FAIL midflush_row12: got v=%0b hit=%0b want 1/0", o_valid, o_hit); else n_pass++;
    do_lookup(4'd13, 8'hD2);
    n_checks++;
    if ({o_valid, o_hit} !== 2'b10) $display("FAIL midflush_row13: got v=%0b hit=%0b want 1/0", o_valid, o_hit); else n_pass++;
    do_lookup(4'd3, 8'h33);
    n_checks++;
    if ({o_valid, o_hit} !== 2'b10) $display("FAIL midflush_row3: got v=%0b hit=%0b want 1/0", o_valid, o_hit); else n_pass++;
  endtask

  task automatic test_halt();
    do_fill(4'd4, 2'b01, 8'h11);
    do_lookup(4'd4, 8'h11);
    n_checks++;
    if (o_hit_way !== 2'b01) $display("FAIL halt_setup: got %b want 01", o_hit_way); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      i_halt = 1'b1; i_r_valid = 1'b1; i_r_addr = 4'd4; i_tag = 8'h22;
      i_w_valid = 1'b1; i_w_addr = 4'd4; i_w_way = 2'b10; i_w_tag = 8'h22;
      #1;
      n_checks++;
      if (o_ready !== 1'b0) $display("FAIL halt_ready: got %0b want 0", o_ready); else n_pass++;
      step();
      n_checks++;
      if ({o_valid, o_hit_way} !== {1'b1, 2'b01}) $display("FAIL halt_hold: got v=%0b way=%b want 1/01", o_valid, o_hit_way); else n_pass++;
    end
    idle_inputs();
    do_lookup(4'd4, 8'h22);
    n_checks++;
    if ({o_hit, o_victim_way} !== {1'b0, 2'b10}) $display("FAIL halt_ignored_fill: got hit=%0b victim=%b want 0/10", o_hit, o_victim_way); else n_pass++;
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int c = 0; c < 600; c++) begin
      i_halt    = ($urandom_range(0, 9) == 0);
      i_flush   = ($urandom_range(0, 39) == 0);
      i_r_valid = ($urandom_range(0, 9) < 7);
      i_r_addr  = AW'($urandom_range(0, NR - 1));
      i_tag     = TW'($urandom_range(0, 3));
      i_w_valid = ($urandom_range(0, 9) < 4);
      i_w_addr  = AW'($urandom_range(0, NR - 1));
      i_w_way   = NW'($urandom_range(0, 3));
      i_w_tag   = TW'($urandom_range(0, 3));
      #1;
      exp_ready = !i_halt && (m_flush_left == 0);
      n_checks++;
      if (o_ready !== exp_ready) $display("FAIL rand_ready: got %0b want %0b at cycle %0d", o_ready, exp_ready, c); else n_pass++;
      step();
      n_checks++;
      if ({o_valid, o_tag, o_hit, o_hit_way, o_victim_way} !== {e_valid, e_tag, |e_hit_way, e_hit_way, e_victim})
        $display("FAIL rand_lookup: got v=%0b tag=%h hit=%0b way=%b victim=%b want v=%0b tag=%h hit=%0b way=%b victim=%b at cycle %0d",
                 o_valid, o_tag, o_hit, o_hit_way, o_victim_way, e_valid, e_tag, |e_hit_way, e_hit_way, e_victim, c);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_lookup();
    test_victim();
    test_same_cycle();
    test_flush();
    test_reset_mid_flush();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
